mul_rr_sched: RTL and testbench

Round-robin scheduler that shares one combinational 8x8 multiplier (`mul`: a, b → y) among N_REQ requesters. Each requester offers operands on a valid/ready handshake. The block grants one requester at a time, latches its operands, registers the product, and returns it with the requester's ID on a response handshake. It sits between the multiply clients and the single `mul` instance, which it owns.

---
 rtl/mul_sched_pkg.sv | 46 ++++
 rtl/mul.sv | 18 +
 rtl/mul_rr_sched.sv | 127 ++++++++++++
 tb/tb_mul_rr_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_sched_pkg
// Brief    : Shared types, defaults and round-robin pick helper for mul_rr_sched
// Revision : 1.0 - initial release
// ============================================================================
package mul_sched_pkg;

    localparam int c_DEF_WIDTH = 8;
    localparam int c_DEF_N_REQ = 4;
    localparam int c_PICK_MAX  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } rr_pick_t;

    // First set bit at or after ptr, wrapping at n; ptr < n <= c_PICK_MAX.
    function automatic rr_pick_t rr_pick(input logic [c_PICK_MAX-1:0] valid,
                                         input logic [7:0]            ptr,
                                         input logic [7:0]            n);
        rr_pick_t   r;
        logic [7:0] k;
        r.found = 1'b0;
        r.idx   = 8'd0;
        for (int i = 0; i < c_PICK_MAX; i++) begin
            k = ptr + 8'(i);
            if (k >= n) begin
                k = k - n;
            end
            if ((8'(i) < n) && !r.found && valid[k[5:0]]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul.sv
`default_nettype none
// ============================================================================
// Module   : mul
// Brief    : Combinational unsigned WIDTH x WIDTH multiplier, full-width product
// Revision : 1.0 - initial release
// ============================================================================
module mul #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] y
);

    assign y = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule
`default_nettype wire

// File: rtl/mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mul_rr_sched
// Brief    : Round-robin scheduler sharing one multiplier among N_REQ clients
// Revision : 1.0 - initial release
// ============================================================================
module mul_rr_sched
    import mul_sched_pkg::*;
#(
    parameter  int N_REQ = c_DEF_N_REQ,
    parameter  int WIDTH = c_DEF_WIDTH,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_y
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_y_q, rsp_y_d;

    rr_pick_t             w_pick;
    logic [ID_W-1:0]      w_idx;
    logic [WIDTH-1:0]     w_sel_a, w_sel_b;
    logic [2*WIDTH-1:0]   w_y;
    logic [N_REQ-1:0]     w_ready;

    assign w_pick = rr_pick(c_PICK_MAX'(req_valid), 8'(rr_ptr_q), 8'(N_REQ));
    assign w_idx  = ID_W'(w_pick.idx);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    mul #(.WIDTH(WIDTH)) u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .y (w_y)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        w_ready     = '0;
        case (state_q)
            IDLE: begin
                // The grant itself is the accept: ready is only raised on a valid bit.
                if (w_pick.found) begin
                    w_ready[w_idx] = 1'b1;
                    op_a_d         = w_sel_a;
                    op_b_d         = w_sel_b;
                    id_d           = w_idx;
                    rr_ptr_d       = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);
                    state_d        = CALC;
                end
            end
            CALC: begin
                rsp_y_d     = w_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
        end
    end

    assign req_ready = rst ? '0 : w_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_rr_sched
// Brief    : Self-checking bench for mul_rr_sched with reference model and scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_rr_sched;

    localparam int c_N = 4;
    localparam int c_W = 8;

    logic              clk;
    logic              rst;
    logic [c_N-1:0]    req_valid;
    logic [c_N-1:0]    req_ready;
    logic [c_N*c_W-1:0] req_a;
    logic [c_N*c_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [2*c_W-1:0]  rsp_y;

    mul_rr_sched #(.N_REQ(c_N), .WIDTH(c_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [15:0] y;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          m_state = 0;
    int          m_ptr   = 0;
    int          w;
    logic [3:0]  exp_ready;
    logic [7:0]  ea, eb;
    logic [1:0]  hold_id;
    logic [15:0] hold_y;
    bit          held;

    // Reference model evaluated mid-cycle: predicts what the next rising edge does.
    always @(negedge clk) begin
        if (rst) begin
            m_state = 0;
            m_ptr   = 0;
            held    = 1'b0;
            sb.delete();
        end else begin
            case (m_state)
                0: begin
                    exp_ready = '0;
                    w = -1;
                    for (int k = 0; k < c_N; k++) begin
                        if (w < 0 && req_valid[(m_ptr + k) % c_N]) w = (m_ptr + k) % c_N;
                    end
                    if (w >= 0) exp_ready[w] = 1'b1;
                    chk("mon_req_ready", 32'(req_ready), 32'(exp_ready));
                    chk("mon_idle_rsp_valid", 32'(rsp_valid), 32'd0);
                    if (w >= 0) begin
                        ea   = req_a[w*c_W +: c_W];
                        eb   = req_b[w*c_W +: c_W];
                        e.id = 2'(w);
                        e.y  = 16'(ea) * 16'(eb);
                        sb.push_back(e);
                        m_ptr   = (w + 1) % c_N;
                        m_state = 1;
                    end
                end
                1: begin
                    chk("mon_calc_ready", 32'(req_ready), 32'd0);
                    chk("mon_calc_rsp_valid", 32'(rsp_valid), 32'd0);
                    held    = 1'b0;
                    m_state = 2;
                end
                default: begin
                    chk("mon_resp_ready", 32'(req_ready), 32'd0);
                    chk("mon_resp_valid", 32'(rsp_valid), 32'd1);
                    if (held) begin
                        chk("mon_hold_id", 32'(rsp_id), 32'(hold_id));
                        chk("mon_hold_y", 32'(rsp_y), 32'(hold_y));
                    end else begin
                        hold_id = rsp_id;
                        hold_y  = rsp_y;
                        held    = 1'b1;
                    end
                    if (rsp_ready) begin
                        if (sb.size() == 0) begin
                            chk("mon_sb_underflow", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("sb_id", 32'(rsp_id), 32'(e.id));
                            chk("sb_y", 32'(rsp_y), 32'(e.y));
                        end
                        m_state = 0;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*c_W +: c_W] = a;
        req_b[i*c_W +: c_W] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_y", 32'(rsp_y), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        tick();

        // Round-robin across all four requesters
        for (int i = 0; i < c_N; i++) set_op(i, 8'(i + 1), 8'd2);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % c_N)));
            tick();
            tick();
            chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % c_N));
            chk("rr_rsp_y", 32'(rsp_y), 32'(2 * ((k % c_N) + 1)));
            tick();
        end
        req_valid = '0;

        // Single requester, pointer at 1
        set_op(1, 8'd12, 8'd10);
        req_valid = 4'b0010;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd1);
        chk("single_rsp_y", 32'(rsp_y), 32'd120);
        tick();

        // Grant requester 2 so the pointer sits at 3, then wrap and skip
        set_op(2, 8'd3, 8'd4);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid = 4'b0101;
        #1;
        chk("wrap_grant0", 32'(req_ready), 32'b0001);
        tick();
        tick();
        chk("wrap_rsp_id0", 32'(rsp_id), 32'd0);
        tick();
        chk("wrap_grant2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        tick();
        chk("wrap_rsp_id2", 32'(rsp_id), 32'd2);
        chk("wrap_rsp_y2", 32'(rsp_y), 32'd12);
        tick();

        // Back-pressure with the maximum product and other requests pending
        set_op(3, 8'd255, 8'd255);
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant3", 32'(req_ready), 32'b1000);
        tick();
        tick();
        chk("bp_rsp_y", 32'(rsp_y), 32'hFE01);
        chk("bp_rsp_id", 32'(rsp_id), 32'd3);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_y", 32'(rsp_y), 32'hFE01);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_indep", 32'(req_ready), 32'd0);
        tick();
        chk("bp_next_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Asynchronous reset during CALC
        set_op(2, 8'd3, 8'd4);
        req_valid = 4'b0100;
        #1;
        chk("rst_pre_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        rst       = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_id", 32'(rsp_id), 32'd0);
        chk("rst_mid_y", 32'(rsp_y), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'hF;
        #1;
        chk("rst_ptr_restart", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Random regression, checked by the model and scoreboard
        for (int k = 0; k < 200; k++) begin
            req_valid = 4'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
